// File: rtl/prio_merge_pkg.sv
// -----------------------------------------------------------------------------
// prio_merge_pkg
//   Shared declarations for the prio_merge priority merger.
//   - state_e : arbiter lock state (IDLE / LOCKED)
//   - cw_of() : channel-index width for a given channel count, never below 1
// -----------------------------------------------------------------------------
package prio_merge_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Width needed to index n channels; a single channel still gets one bit.
  function automatic int unsigned cw_of(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/prio_merge_buf.sv
// -----------------------------------------------------------------------------
// prio_merge_buf
//   Two-entry FIFO holding {data, last, chan} beats for the merger output.
//   The head entry is registered and drives the out_* ports directly; when
//   the FIFO drains the head keeps the last value it presented.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   push_i                     write one beat (ignored when full without pop)
//   push_data_i/_last_i/_chan_i  beat contents
//   pop_i                      consume head (ignored when empty)
//   count_o                    occupancy, 0..2
//   out_valid_o                head present
//   out_data_o/_last_o/_chan_o head contents
// -----------------------------------------------------------------------------
module prio_merge_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic [CW-1:0]    push_chan_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  output logic [CW-1:0]    out_chan_o
);

  localparam int unsigned EW = WIDTH + 1 + CW;

  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic [EW-1:0] in_ent;
  logic          do_pop;
  logic          do_push;

  assign in_ent  = {push_data_i, push_last_i, push_chan_i};
  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  // Head/tail shift organisation: the head register only changes when a new
  // beat becomes the head, so an empty FIFO keeps showing the last popped beat.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = in_ent;
        end else begin
          tail_d = in_ent;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_ent;
        end else begin
          head_d = tail_q;
          tail_d = in_ent;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q[EW-1 -: WIDTH];
  assign out_last_o  = head_q[CW];
  assign out_chan_o  = head_q[CW-1:0];

endmodule

// File: rtl/prio_merge.sv
// -----------------------------------------------------------------------------
// prio_merge
//   Merges NCH source channels into one output stream. A fixed-priority
//   arbiter (highest or lowest valid index, per LAST_WINS) picks a channel;
//   once a non-final beat is taken the arbiter locks onto that channel until
//   its end-of-packet beat is accepted, so packets are never interleaved.
//   Accepted beats pass through a 2-entry FIFO (prio_merge_buf).
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   src_valid    per-channel beat valid            [NCH]
//   src_data     per-channel data, ch i at [i*WIDTH +: WIDTH]
//   src_last     per-channel end-of-packet         [NCH]
//   src_ready    per-channel accept, one-hot or zero [NCH]
//   out_valid    head entry present
//   out_data     head data
//   out_last     head end-of-packet
//   out_chan     head source channel index         [CW]
//   out_ready    downstream accept
// -----------------------------------------------------------------------------
module prio_merge
  import prio_merge_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned NCH       = 3,
  parameter  int unsigned LAST_WINS = 1,
  localparam int unsigned CW        = cw_of(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       src_valid,
  input  logic [NCH*WIDTH-1:0] src_data,
  input  logic [NCH-1:0]       src_last,
  output logic [NCH-1:0]       src_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [CW-1:0]        out_chan,
  input  logic                 out_ready
);

  state_e          state_q, state_d;
  logic [CW-1:0]   lk_q, lk_d;

  logic            sel_found;
  logic [CW-1:0]   sel;
  logic [WIDTH-1:0] sel_data;
  logic            sel_last;
  logic [1:0]      buf_count;
  logic            accept;

  // Scan order makes the winning channel the last one visited: ascending for
  // highest-index priority, descending for lowest-index priority.
  always_comb begin : arb
    automatic int unsigned ch;
    sel_found = 1'b0;
    sel       = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ch = (LAST_WINS != 0) ? i : (NCH - 1 - i);
      if (src_valid[ch] && ((state_q == IDLE) || (lk_q == CW'(ch)))) begin
        sel_found = 1'b1;
        sel       = CW'(ch);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (CW'(i) == sel) begin
        sel_data = src_data[i*WIDTH +: WIDTH];
        sel_last = src_last[i];
      end
    end
  end

  // Space is judged on the registered count only, so src_ready never depends
  // combinationally on out_ready.
  assign accept = sel_found && (buf_count != 2'd2) && rst_n;

  always_comb begin
    src_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      src_ready[i] = accept && (CW'(i) == sel);
    end
  end

  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    if (accept) begin
      if ((state_q == IDLE) && !sel_last) begin
        state_d = LOCKED;
        lk_d    = sel;
      end else if ((state_q == LOCKED) && sel_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lk_q    <= '0;
    end else begin
      state_q <= state_d;
      lk_q    <= lk_d;
    end
  end

  prio_merge_buf #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (accept),
    .push_data_i(sel_data),
    .push_last_i(sel_last),
    .push_chan_i(sel),
    .pop_i      (out_ready),
    .count_o    (buf_count),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_chan_o (out_chan)
  );

endmodule

// File: tb/tb_prio_merge.sv
// -----------------------------------------------------------------------------
// tb_prio_merge
//   Two instances (LAST_WINS=1 and LAST_WINS=0) driven by independent random
//   sources that hold each beat until it is accepted. A queue-style reference
//   model per instance predicts src_ready and the out_* head every cycle.
//   Traffic phases: free flow, random backpressure, heavy backpressure with a
//   mid-packet reset, and all-sources-busy streaming.
// -----------------------------------------------------------------------------
module tb_prio_merge;

  localparam int unsigned W    = 8;
  localparam int unsigned N    = 3;
  localparam int          NCYC = 3000;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    int unsigned  c;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic out_ready;

  logic [N-1:0]   sv  [2];
  logic [N*W-1:0] sd  [2];
  logic [N-1:0]   sl  [2];
  logic [N-1:0]   rdy [2];
  logic           ov  [2];
  logic [W-1:0]   od  [2];
  logic           ol  [2];
  logic [1:0]     oc  [2];

  always #5 clk = ~clk;

  prio_merge #(.WIDTH(W), .NCH(N), .LAST_WINS(1)) u_lw1 (
    .clk(clk), .rst_n(rst_n),
    .src_valid(sv[0]), .src_data(sd[0]), .src_last(sl[0]), .src_ready(rdy[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_last(ol[0]), .out_chan(oc[0]),
    .out_ready(out_ready)
  );

  prio_merge #(.WIDTH(W), .NCH(N), .LAST_WINS(0)) u_lw0 (
    .clk(clk), .rst_n(rst_n),
    .src_valid(sv[1]), .src_data(sd[1]), .src_last(sl[1]), .src_ready(rdy[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_last(ol[1]), .out_chan(oc[1]),
    .out_ready(out_ready)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Source beat state per instance/channel
  logic         bv [2][N];
  logic [W-1:0] bd [2][N];
  logic         bl [2][N];

  // Reference model per instance
  logic        mlock [2];
  int unsigned mlk   [2];
  ent_t        mq    [2][2];
  int unsigned mcnt  [2];
  ent_t        mhd   [2];
  int          macc  [2];

  task automatic model_reset(input int k);
    mlock[k]  = 1'b0;
    mlk[k]    = 0;
    mcnt[k]   = 0;
    mhd[k].d  = '0;
    mhd[k].l  = 1'b0;
    mhd[k].c  = 0;
  endtask

  task automatic new_beat(input int k, input int c);
    bv[k][c] = 1'b1;
    bd[k][c] = W'($urandom);
    bl[k][c] = ($urandom_range(3) == 0);
  endtask

  task automatic drive_srcs();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < N; c++) begin
        sv[k][c]          = bv[k][c];
        sd[k][c*W +: W]   = bd[k][c];
        sl[k][c]          = bl[k][c];
      end
    end
  endtask

  initial begin
    int           s;
    int           phase;
    logic [N-1:0] er;
    ent_t         hv;
    logic         pop;

    rst_n     = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      macc[k] = -1;
      for (int c = 0; c < N; c++) begin
        bv[k][c] = 1'b0;
        bd[k][c] = '0;
        bl[k][c] = 1'b0;
      end
    end
    drive_srcs();
    @(posedge clk);
    #1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        // Winner among eligible valid channels: highest index for instance 0,
        // lowest index for instance 1.
        s = -1;
        if (rst_n) begin
          for (int c = 0; c < N; c++) begin
            if (bv[k][c] && (!mlock[k] || (mlk[k] == c))) begin
              if (k == 0 || s < 0) s = c;
            end
          end
        end
        er = '0;
        if (s >= 0 && mcnt[k] < 2) er[s] = 1'b1;

        if (mcnt[k] > 0) hv = mq[k][0];
        else             hv = mhd[k];

        check_eq($sformatf("ready%0d", k), 64'(rdy[k]), 64'(er));
        check_eq($sformatf("ovalid%0d", k), 64'(ov[k]), 64'(mcnt[k] > 0));
        check_eq($sformatf("odata%0d", k), 64'(od[k]), 64'(hv.d));
        check_eq($sformatf("olast%0d", k), 64'(ol[k]), 64'(hv.l));
        check_eq($sformatf("ochan%0d", k), 64'(oc[k]), 64'(hv.c));

        if (!rst_n) begin
          model_reset(k);
          macc[k] = -1;
        end else begin
          pop     = (mcnt[k] > 0) && out_ready;
          macc[k] = (er != '0) ? s : -1;
          if (pop) begin
            mhd[k]   = mq[k][0];
            mq[k][0] = mq[k][1];
            mcnt[k]--;
          end
          if (er != '0) begin
            mq[k][mcnt[k]].d = bd[k][s];
            mq[k][mcnt[k]].l = bl[k][s];
            mq[k][mcnt[k]].c = s;
            mcnt[k]++;
            if (!mlock[k] && !bl[k][s]) begin
              mlock[k] = 1'b1;
              mlk[k]   = s;
            end else if (mlock[k] && bl[k][s]) begin
              mlock[k] = 1'b0;
            end
          end
        end
      end

      @(posedge clk);
      #1;
      phase = ((cyc + 1) / 100) % 4;
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < N; c++) begin
          if (macc[k] == c) begin
            if (phase == 3 || $urandom_range(1) == 1) new_beat(k, c);
            else bv[k][c] = 1'b0;
          end else if (!bv[k][c] && (phase == 3 || $urandom_range(2) == 0)) begin
            new_beat(k, c);
          end
        end
      end
      rst_n = !((cyc + 1) < 2 || ((cyc + 1) % 400) == 290);
      case (phase)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(1) == 1);
        2:       out_ready = ($urandom_range(9) == 0);
        default: out_ready = 1'b1;
      endcase
      drive_srcs();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
